// File: rtl/bus_arbiter_4to2_if.sv
// Request/grant bundle between four bus masters and the 4-to-2 arbiter.
// The arbiter connects through the slave modport, the masters through the master modport.
interface bus_arbiter_4to2_if;
  logic [3:0] req;
  logic [1:0] grant_idx;
  logic       grant_en;
  logic       busy;
  logic       timeout;

  modport master (output req, input grant_idx, grant_en, busy, timeout);
  modport slave  (input req, output grant_idx, grant_en, busy, timeout);
endinterface

// File: rtl/bus_arbiter_4to2.sv
// Four-master bus arbiter with an IDLE/ARB/OWN/GAP sequence and a hold-time limit.
// Define ARB_ROUND_ROBIN_EN for round-robin winner selection; fixed lowest-index priority otherwise.
module bus_arbiter_4to2 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  bus_arbiter_4to2_if.slave    bus,
  output logic [1:0]           dbg_state,
  output logic [1:0]           dbg_last_idx
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARB  = 2'd1;
  localparam logic [1:0] OWN  = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_MAX - 1);

  // Handshake: a master raises req[i] and holds it level for as long as it
  // wants or owns the bus; ownership is signalled by grant_en=1 with
  // grant_idx=i, and it ends the cycle after the master drops req[i] or the
  // hold limit expires (then timeout pulses for one cycle).
  logic [1:0] state;
  logic [1:0] last_idx;
  logic [7:0] hold_cnt;
  logic [1:0] winner;

`ifdef ARB_ROUND_ROBIN_EN
  logic       found;
  logic [1:0] cand;

  always_comb begin
    winner = 2'b00;
    found  = 1'b0;
    cand   = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      cand = last_idx + 2'(i);
      if (!found && bus.req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end
`else
  always_comb begin
    winner = 2'b00;
    for (int i = 3; i >= 0; i--) begin
      if (bus.req[i]) winner = 2'(i);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.grant_idx <= 2'b00;
      bus.grant_en  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.timeout   <= 1'b0;
      hold_cnt      <= 8'd0;
      last_idx      <= 2'b11;
    end else begin
      bus.timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state    <= ARB;
            bus.busy <= 1'b1;
          end
        end
        ARB: begin
          if (bus.req == 4'b0000) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            state         <= OWN;
            bus.grant_idx <= winner;
            bus.grant_en  <= 1'b1;
            last_idx      <= winner;
            hold_cnt      <= 8'd0;
          end
        end
        OWN: begin
          // An owner releasing on the limit cycle counts as a normal release.
          if (!bus.req[bus.grant_idx]) begin
            state        <= GAP;
            bus.grant_en <= 1'b0;
          end else if (hold_cnt == HOLD_LIMIT) begin
            state        <= GAP;
            bus.grant_en <= 1'b0;
            bus.timeout  <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        GAP: begin
          if (|bus.req) begin
            state <= ARB;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          bus.grant_en <= 1'b0;
          bus.busy     <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state    = state;
  assign dbg_last_idx = last_idx;

endmodule

// File: tb/tb_bus_arbiter_4to2.sv
// Directed and randomized bench for bus_arbiter_4to2 against a cycle-level ownership model.
// Build with or without ARB_ROUND_ROBIN_EN; the model and sequences follow the same macro.
module tb_bus_arbiter_4to2;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  logic [1:0] dbg_last_idx;

  bus_arbiter_4to2_if bus ();

  bus_arbiter_4to2 #(.HOLD_MAX(HOLD)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .dbg_state    (dbg_state),
    .dbg_last_idx (dbg_last_idx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the bus, for how many cycles, and what phase
  // the bus is in between owners.
  bit m_owning;
  bit m_arbitrating;
  bit m_turnaround;
  bit m_timeout;
  int m_owner;
  int m_last;
  int m_owned_cycles;

  function automatic int pick(input logic [3:0] r, input int last);
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
`else
    for (int k = 0; k < 4; k++) begin
      if (r[k]) return k;
    end
`endif
    return 0;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic rs);
    m_timeout = 1'b0;
    if (rs) begin
      m_owning       = 1'b0;
      m_arbitrating  = 1'b0;
      m_turnaround   = 1'b0;
      m_owner        = 0;
      m_last         = 3;
      m_owned_cycles = 0;
    end else if (m_owning) begin
      if (!r[m_owner]) begin
        m_owning     = 1'b0;
        m_turnaround = 1'b1;
      end else if (m_owned_cycles == HOLD) begin
        m_owning     = 1'b0;
        m_turnaround = 1'b1;
        m_timeout    = 1'b1;
      end else begin
        m_owned_cycles++;
      end
    end else if (m_arbitrating) begin
      m_arbitrating = 1'b0;
      if (r != 4'b0000) begin
        m_owner        = pick(r, m_last);
        m_last         = m_owner;
        m_owning       = 1'b1;
        m_owned_cycles = 1;
      end
    end else begin
      m_turnaround  = 1'b0;
      m_arbitrating = (r != 4'b0000);
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("grant_en", 8'(bus.grant_en), 8'(m_owning));
    chk("grant_idx", 8'(bus.grant_idx), 8'(m_owner));
    chk("busy", 8'(bus.busy), 8'(m_owning | m_arbitrating | m_turnaround));
    chk("timeout", 8'(bus.timeout), 8'(m_timeout));
    chk("last_idx", 8'(dbg_last_idx), 8'(m_last));
  endtask

  task automatic tick(input logic [3:0] r, input logic rs);
    bus.req = r;
    rst     = rs;
    @(posedge clk);
    #1;
    model_step(r, rs);
    check_model();
  endtask

  logic [3:0] base;
  logic [3:0] r;
  logic [1:0] exp_q[$];
  logic       prev_en;
  int         own_ct;

  initial begin
    rst     = 1'b1;
    bus.req = 4'b0000;
    model_step(4'b0000, 1'b1);

    // Reset state
    tick(4'b0000, 1'b1);
    tick(4'b0000, 1'b1);
    chk("rst_grant_en", 8'(bus.grant_en), 8'd0);
    chk("rst_grant_idx", 8'(bus.grant_idx), 8'd0);
    chk("rst_busy", 8'(bus.busy), 8'd0);
    chk("rst_last_idx", 8'(dbg_last_idx), 8'd3);

    // No grant right after reset release; single request latency
    tick(4'b0000, 1'b0);
    chk("post_rst_grant_en", 8'(bus.grant_en), 8'd0);
    tick(4'b0100, 1'b0);
    chk("lat_busy", 8'(bus.busy), 8'd1);
    chk("lat_grant_en_early", 8'(bus.grant_en), 8'd0);
    tick(4'b0100, 1'b0);
    chk("lat_grant_en", 8'(bus.grant_en), 8'd1);
    chk("lat_grant_idx", 8'(bus.grant_idx), 8'd2);
    tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b0);

    // All contenders held, each owner releasing after 3 cycles
    tick(4'b0000, 1'b1);
    tick(4'b0000, 1'b0);
`ifdef ARB_ROUND_ROBIN_EN
    base  = 4'b1111;
    exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
    base  = 4'b1010;
    exp_q = {2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
`endif
    r       = base;
    prev_en = 1'b0;
    own_ct  = 0;
    for (int t = 0; t < 120 && exp_q.size() != 0; t++) begin
      tick(r, 1'b0);
      if (bus.grant_en && !prev_en) begin
        chk("seq_idx", 8'(bus.grant_idx), 8'(exp_q.pop_front()));
        own_ct = 1;
      end else if (bus.grant_en) begin
        own_ct++;
      end
      r = base;
      if (bus.grant_en && own_ct == 3) r[bus.grant_idx] = 1'b0;
      prev_en = bus.grant_en;
    end
    chk("seq_complete", 8'(exp_q.size()), 8'd0);
    tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b0);

    // Hold limit with a persistent requester
    tick(4'b0000, 1'b1);
    tick(4'b0000, 1'b0);
    tick(4'b0001, 1'b0);
    tick(4'b0001, 1'b0);
    chk("hold_first", 8'(bus.grant_en), 8'd1);
    for (int i = 0; i < 3; i++) begin
      tick(4'b0001, 1'b0);
      chk("hold_en", 8'(bus.grant_en), 8'd1);
      chk("hold_no_timeout", 8'(bus.timeout), 8'd0);
    end
    tick(4'b0001, 1'b0);
    chk("hold_drop_en", 8'(bus.grant_en), 8'd0);
    chk("hold_timeout", 8'(bus.timeout), 8'd1);
    tick(4'b0001, 1'b0);
    chk("hold_timeout_end", 8'(bus.timeout), 8'd0);
    chk("hold_arb_en", 8'(bus.grant_en), 8'd0);
    tick(4'b0001, 1'b0);
    chk("regrant_en", 8'(bus.grant_en), 8'd1);
    chk("regrant_idx", 8'(bus.grant_idx), 8'd0);
    // Release on the limit cycle is a normal release
    for (int i = 0; i < 3; i++) tick(4'b0001, 1'b0);
    tick(4'b0000, 1'b0);
    chk("limit_release_en", 8'(bus.grant_en), 8'd0);
    chk("limit_release_timeout", 8'(bus.timeout), 8'd0);
    tick(4'b0000, 1'b0);

    // Request that vanishes before arbitration
    tick(4'b0000, 1'b1);
    tick(4'b0000, 1'b0);
    tick(4'b0010, 1'b0);
    chk("pulse_busy", 8'(bus.busy), 8'd1);
    tick(4'b0000, 1'b0);
    chk("pulse_idle_busy", 8'(bus.busy), 8'd0);
    chk("pulse_grant_en", 8'(bus.grant_en), 8'd0);
    tick(4'b0000, 1'b0);
    chk("pulse_grant_en_late", 8'(bus.grant_en), 8'd0);

    // Reset while owning
    tick(4'b1000, 1'b0);
    tick(4'b1000, 1'b0);
    chk("own_idx3", 8'(bus.grant_idx), 8'd3);
    tick(4'b1000, 1'b1);
    chk("midrst_grant_en", 8'(bus.grant_en), 8'd0);
    chk("midrst_grant_idx", 8'(bus.grant_idx), 8'd0);
    chk("midrst_busy", 8'(bus.busy), 8'd0);
    tick(4'b1000, 1'b0);
    chk("midrst_after_en", 8'(bus.grant_en), 8'd0);
    tick(4'b1000, 1'b0);
    chk("midrst_regrant", 8'(bus.grant_en), 8'd1);

    // Randomized traffic with occasional resets
    r = 4'b0000;
    for (int t = 0; t < 800; t++) begin
      if ($urandom_range(0, 4) == 0) r = 4'($urandom_range(0, 15));
      tick(r, $urandom_range(0, 63) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
